// File: rtl/rec_fn_pkg.sv
// Shared constants and types for recoded-to-IEEE binary64 conversion.
package rec_fn_pkg;
    localparam int EXP_W     = 11;
    localparam int SIG_W     = 53;
    localparam int REC_EXP_W = EXP_W + 1;
    localparam int FRACT_W   = SIG_W - 1;

    localparam logic [REC_EXP_W-1:0] MIN_NORM_EXP = 12'd1026;
    localparam logic [REC_EXP_W-1:0] EXP_BIAS_OFF = 12'd1025;
    localparam logic [REC_EXP_W-1:0] MIN_SUB_EXP  = 12'd974;

    localparam logic [63:0] CANON_NAN_64 = 64'h7FF8_0000_0000_0000;

    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_sub;
        logic is_normal;
        logic sign;
    } rec_class_t;
endpackage

// File: rtl/rec_fn_classify.sv
// Combinational decode of a recoded binary64 operand into its value category.
module rec_fn_classify
    import rec_fn_pkg::*;
(
    input  logic [64:0] rec,
    output rec_class_t  cls
);
    logic [REC_EXP_W-1:0] exp;
    logic                 special_zero;
    logic                 finite;

    assign exp          = rec[63:52];
    assign special_zero = (exp[11:9] == 3'b000);
    assign cls.is_inf   = (exp[11:9] == 3'b110);
    assign cls.is_nan   = (exp[11:9] == 3'b111);
    assign finite       = !special_zero && !cls.is_inf && !cls.is_nan;

    // Finite values too small even for a subnormal collapse into zero.
    assign cls.is_zero   = special_zero || (finite && (exp < MIN_SUB_EXP));
    assign cls.is_sub    = finite && (exp >= MIN_SUB_EXP) && (exp < MIN_NORM_EXP);
    assign cls.is_normal = finite && (exp >= MIN_NORM_EXP);
    assign cls.sign      = rec[64];
endmodule

// File: rtl/recfn_to_fn_pipe.sv
// Two-stage valid/ready pipeline converting recoded binary64 to IEEE binary64 plus fclass.
// Build option: RECFN_TO_FN_CANON_NAN_EN forces every NaN result to the canonical quiet NaN.
module recfn_to_fn_pipe
    import rec_fn_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [64:0] io_in_bits,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [63:0] io_out_bits,
    output logic [9:0]  io_out_class
);
    rec_class_t           in_cls;
    logic                 s1_valid_reg;
    rec_class_t           s1_cls_reg;
    logic [REC_EXP_W-1:0] s1_exp_reg;
    logic [FRACT_W-1:0]   s1_fract_reg;
    logic                 s2_valid_reg;
    logic [63:0]          s2_bits_reg;
    logic [9:0]           s2_class_reg;
    logic                 s1_load;
    logic                 s2_load;
    logic [5:0]           sub_shift;
    logic [FRACT_W-1:0]   sub_fract;
    logic [EXP_W-1:0]     norm_exp;
    logic [63:0]          pack_bits;
    logic [9:0]           pack_class;

    rec_fn_classify u_classify (
        .rec (io_in_bits),
        .cls (in_cls)
    );

    assign s2_load     = !s2_valid_reg || io_out_ready;
    assign s1_load     = !s1_valid_reg || s2_load;
    assign io_in_ready = s1_load || !reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s1_load) s1_valid_reg <= io_in_valid;
            if (s2_load) s2_valid_reg <= s1_valid_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (s1_load && io_in_valid) begin
            s1_cls_reg   <= in_cls;
            s1_exp_reg   <= io_in_bits[63:52];
            s1_fract_reg <= io_in_bits[51:0];
        end
        if (s2_load && s1_valid_reg) begin
            s2_bits_reg  <= pack_bits;
            s2_class_reg <= pack_class;
        end
    end

    // Only the low 6 bits matter: the subnormal shift range is 1..52.
    assign sub_shift = MIN_NORM_EXP[5:0] - s1_exp_reg[5:0];
    assign sub_fract = FRACT_W'({1'b1, s1_fract_reg} >> sub_shift);
    assign norm_exp  = EXP_W'(s1_exp_reg - EXP_BIAS_OFF);

    always_comb begin
        pack_bits  = '0;
        pack_class = '0;
        if (s1_cls_reg.is_nan) begin
`ifdef RECFN_TO_FN_CANON_NAN_EN
            pack_bits = CANON_NAN_64;
`else
            pack_bits = {s1_cls_reg.sign, {EXP_W{1'b1}}, s1_fract_reg};
`endif
            if (s1_fract_reg[FRACT_W-1]) pack_class[FCLASS_QNAN] = 1'b1;
            else                         pack_class[FCLASS_SNAN] = 1'b1;
        end else if (s1_cls_reg.is_inf) begin
            pack_bits = {s1_cls_reg.sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
            if (s1_cls_reg.sign) pack_class[FCLASS_NEG_INF] = 1'b1;
            else                 pack_class[FCLASS_POS_INF] = 1'b1;
        end else if (s1_cls_reg.is_normal) begin
            pack_bits = {s1_cls_reg.sign, norm_exp, s1_fract_reg};
            if (s1_cls_reg.sign) pack_class[FCLASS_NEG_NORM] = 1'b1;
            else                 pack_class[FCLASS_POS_NORM] = 1'b1;
        end else if (s1_cls_reg.is_sub) begin
            pack_bits = {s1_cls_reg.sign, {EXP_W{1'b0}}, sub_fract};
            if (s1_cls_reg.sign) pack_class[FCLASS_NEG_SUB] = 1'b1;
            else                 pack_class[FCLASS_POS_SUB] = 1'b1;
        end else begin
            pack_bits = {s1_cls_reg.sign, 63'b0};
            if (s1_cls_reg.sign) pack_class[FCLASS_NEG_ZERO] = 1'b1;
            else                 pack_class[FCLASS_POS_ZERO] = 1'b1;
        end
    end

    assign io_out_valid = s2_valid_reg && reset;
    assign io_out_bits  = io_out_valid ? s2_bits_reg  : 64'b0;
    assign io_out_class = io_out_valid ? s2_class_reg : 10'b0;
endmodule

// File: tb/tb_recfn_to_fn_pipe.sv
// Scoreboard bench for recfn_to_fn_pipe with a value-level reference model.
module tb_recfn_to_fn_pipe;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_in_valid = 1'b0;
    logic        io_in_ready;
    logic [64:0] io_in_bits = '0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b1;
    logic [63:0] io_out_bits;
    logic [9:0]  io_out_class;

    typedef struct {
        logic [63:0] bits;
        logic [9:0]  cls;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    bit   done = 1'b0;

    recfn_to_fn_pipe dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_class (io_out_class)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Value-level model: a finite operand is 1.fract * 2^(exp-2048).
    function automatic void ref_model(input logic [64:0] r, output logic [63:0] b, output logic [9:0] c);
        logic        s;
        int          ex;
        int          e;
        int          idx;
        logic [51:0] f;
        logic [63:0] m;
        s  = r[64];
        ex = int'(r[63:52]);
        f  = r[51:0];
        b  = {s, 63'b0};
        idx = s ? 3 : 4;
        case (ex / 512)
            0: ;
            6: begin b = {s, 11'h7FF, 52'b0}; idx = s ? 0 : 7; end
            7: begin
`ifdef RECFN_TO_FN_CANON_NAN_EN
                b = 64'h7FF8_0000_0000_0000;
`else
                b = {s, 11'h7FF, f};
`endif
                idx = f[51] ? 9 : 8;
            end
            default: begin
                e = ex - 2048;
                if (e >= -1022) begin
                    b = {s, 11'(e + 1023), f};
                    idx = s ? 1 : 6;
                end else if (e >= -1074) begin
                    // Express the significand in units of the smallest subnormal, 2^-1074.
                    m = {11'b0, 1'b1, f} >> (-1022 - e);
                    b = m;
                    b[63] = s;
                    idx = s ? 2 : 5;
                end
            end
        endcase
        c = 10'(1 << idx);
    endfunction

    function automatic logic [64:0] gen_op();
        int          cat;
        logic [11:0] ex;
        int          bnd;
        cat = $urandom_range(0, 9);
        case (cat)
            0: ex = {3'b000, 9'($urandom_range(0, 511))};
            1: ex = {3'b110, 9'($urandom_range(0, 511))};
            2: ex = {3'b111, 9'($urandom_range(0, 511))};
            3: begin
                bnd = $urandom_range(0, 5);
                case (bnd)
                    0: ex = 12'd973;
                    1: ex = 12'd974;
                    2: ex = 12'd975;
                    3: ex = 12'd1025;
                    4: ex = 12'd1026;
                    default: ex = 12'd1027;
                endcase
            end
            4, 5: ex = 12'($urandom_range(960, 1040));
            default: ex = 12'($urandom_range(512, 3071));
        endcase
        return {1'($urandom_range(0, 1)), ex, 52'({$urandom(), $urandom()})};
    endfunction

    always @(negedge clock) begin
        cyc++;
        case (ready_mode)
            0: io_out_ready = 1'b1;
            1: io_out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2: io_out_ready = ($urandom_range(0, 9) < 7);
            default: io_out_ready = 1'b0;
        endcase
    end

    task automatic send(input logic [64:0] op, input logic [63:0] eb, input logic [9:0] ec, input bit lat);
        int   waited;
        exp_t x;
        bit   exp_rdy;
        waited = 0;
        @(negedge clock);
        io_in_valid = 1'b1;
        io_in_bits  = op;
        forever begin
            #1;
            exp_rdy = !(sb.size() >= 2 && !io_out_ready);
            chk("in_ready", 64'(io_in_ready), 64'(exp_rdy));
            if (io_in_ready) begin
                x.bits = eb; x.cls = ec; x.acc = cyc; x.lat = lat;
                sb.push_back(x);
                $display("IN  cyc=%0d op=%h exp_bits=%h exp_class=%b", cyc, op, eb, ec);
                break;
            end
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 64'(waited), 64'd0);
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic send_rand(input bit lat);
        logic [64:0] op;
        logic [63:0] b;
        logic [9:0]  c;
        op = gen_op();
        ref_model(op, b, c);
        send(op, b, c, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            io_in_valid = 1'b0;
        end
    endtask

    // Monitor: pops on each output handshake, checks hold-while-stalled and zeroed idle outputs.
    initial begin
        bit          stalled;
        logic [63:0] held_bits;
        logic [9:0]  held_cls;
        exp_t        x;
        stalled = 1'b0;
        held_bits = '0;
        held_cls = '0;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                chk("reset_out_valid", 64'(io_out_valid), 64'd0);
                chk("reset_in_ready", 64'(io_in_ready), 64'd1);
                stalled = 1'b0;
            end else if (io_out_valid) begin
                if (stalled) begin
                    chk("hold_bits", io_out_bits, held_bits);
                    chk("hold_class", 64'(io_out_class), 64'(held_cls));
                end
                if (io_out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", io_out_bits, 64'd0);
                        chk("unexpected_valid", 64'(io_out_valid), 64'd0);
                    end else begin
                        x = sb.pop_front();
                        $display("OUT cyc=%0d bits=%h class=%b exp_bits=%h exp_class=%b",
                                 cyc, io_out_bits, io_out_class, x.bits, x.cls);
                        chk("out_bits", io_out_bits, x.bits);
                        chk("out_class", 64'(io_out_class), 64'(x.cls));
                        chk("class_onehot", 64'($countones(io_out_class)), 64'd1);
                        if (x.lat) chk("latency", 64'(cyc - x.acc), 64'd2);
                    end
                end
                stalled   = !io_out_ready;
                held_bits = io_out_bits;
                held_cls  = io_out_class;
            end else begin
                if (stalled) chk("dropped_while_stalled", 64'(io_out_valid), 64'd1);
                chk("idle_bits_zero", io_out_bits, 64'd0);
                chk("idle_class_zero", 64'(io_out_class), 64'd0);
                stalled = 1'b0;
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b0;
        ready_mode = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Known values, each sent into an empty pipeline to observe the 2-cycle latency.
        send(65'h0_8000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 10'b00_0100_0000, 1'b1); idle(3);
        send(65'h1_C000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 10'b00_0000_0001, 1'b1); idle(3);
        send(65'h0_3CE0_0000_0000_0000, 64'h0000_0000_0000_0001, 10'b00_0010_0000, 1'b1); idle(3);
        send(65'h0_4010_0000_0000_0000, 64'h0008_0000_0000_0000, 10'b00_0010_0000, 1'b1); idle(3);
        send(65'h0_3CD0_0000_0000_0000, 64'h0000_0000_0000_0000, 10'b00_0001_0000, 1'b1); idle(3);
        send(65'h1_0000_0000_0000_0000, 64'h8000_0000_0000_0000, 10'b00_0000_1000, 1'b1); idle(3);
`ifdef RECFN_TO_FN_CANON_NAN_EN
        send(65'h1_E000_0000_0000_0001, 64'h7FF8_0000_0000_0000, 10'b01_0000_0000, 1'b1); idle(3);
        send(65'h0_E008_0000_0000_0000, 64'h7FF8_0000_0000_0000, 10'b10_0000_0000, 1'b1); idle(3);
`else
        send(65'h1_E000_0000_0000_0001, 64'hFFF0_0000_0000_0001, 10'b01_0000_0000, 1'b1); idle(3);
        send(65'h0_E008_0000_0000_0000, 64'h7FF8_0000_0000_0000, 10'b10_0000_0000, 1'b1); idle(3);
`endif

        // Back-pressure: four back-to-back operands against a 1,0,0,1 ready pattern.
        ready_mode = 1;
        repeat (4) send_rand(1'b0);
        idle(12);
        ready_mode = 0;
        idle(4);

        // Reset mid-flight: two operands in, then a one-cycle reset discards them.
        ready_mode = 3;
        repeat (2) send_rand(1'b0);
        @(negedge clock);
        io_in_valid = 1'b0;
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        ready_mode = 0;
        #1;
        chk("post_reset_out_valid", 64'(io_out_valid), 64'd0);
        idle(6);

        // Randomized traffic with random stalls and gaps.
        ready_mode = 2;
        repeat (400) begin
            send_rand(1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        ready_mode = 0;

        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        chk("drain_remaining", 64'(sb.size()), 64'd0);
        idle(2);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/recfn_to_fn_pipe.md
RECFN_TO_FN_PIPE -- requirements
Module: recfn_to_fn_pipe

Interface
REQ-001 SHALL have `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-low reset (0 = reset), sampled on `clock`.
REQ-003 SHALL have `io_in_valid`, input, 1 bit: recoded operand present.
REQ-004 SHALL have `io_in_ready`, output, 1 bit: block accepts the operand this cycle.
REQ-005 SHALL have `io_in_bits`, input, 65 bits: recoded double; [64] sign, [63:52] exp (12 bits), [51:0] fract.
REQ-006 SHALL have `io_out_valid`, output, 1 bit: result present.
REQ-007 SHALL have `io_out_ready`, input, 1 bit: consumer accepts the result.
REQ-008 SHALL have `io_out_bits`, output, 64 bits: IEEE-754 binary64 result.
REQ-009 SHALL have `io_out_class`, output, 10 bits: RISC-V fclass one-hot.

Function
REQ-010 SHALL be a 2-stage valid/ready pipeline: S1 decodes/classifies; S2 packs the result.
- Latency: 2 cycles from input handshake to `io_out_valid` with no stall.
- Throughput: 1 result per cycle.
REQ-011 SHALL apply these advance rules:
- S2 loads when `!s2_valid || io_out_ready`.
- S1 loads when `!s1_valid || S2 loads`.
- `io_in_ready` = S1 loads, purely combinational; it never depends on `io_in_valid`.
REQ-012 SHALL hold `io_out_bits` and `io_out_class` stable while `io_out_valid && !io_out_ready`; no result is dropped or duplicated.
REQ-013 SHALL pass one result per cycle when `io_in_valid`, `io_out_ready` and the pipeline are all full simultaneously, with no bubble.
REQ-014 SHALL decode the operand from exp[11:9] as follows:
- 000 -> zero.
- 110 -> infinity.
- 111 -> NaN.
- otherwise -> finite.
REQ-015 SHALL pack a finite operand with exp >= 1026 as a normal: IEEE exp = (exp - 1025)[10:0], fract passed through unchanged.
REQ-016 SHALL pack a finite operand with 974 <= exp <= 1025 as a subnormal: IEEE exp = 0, fract = ({1'b1, fract} >> (1026 - exp))[51:0], using a 6-bit shift amount.
REQ-017 SHALL flush a finite operand with exp < 974 to signed zero.
REQ-018 SHALL pack specials as follows:
- Zero -> {sign, 63'b0}.
- Infinity -> {sign, 11'h7FF, 52'b0}.
- NaN -> {sign, 11'h7FF, fract} (macro off).
REQ-019 SHALL set `io_out_class` bits as follows:
- 0 = -inf, 1 = -normal, 2 = -subnormal, 3 = -0.
- 4 = +0, 5 = +subnormal, 6 = +normal, 7 = +inf.
- 8 = sNaN (fract[51] = 0), 9 = qNaN (fract[51] = 1).
- Exactly one bit is set per valid result.

Reset
REQ-020 SHALL clear `s1_valid` and `s2_valid` while `reset` = 0; `io_out_valid` = 0 in the first cycle after reset is released.
REQ-021 SHALL drive `io_in_ready` = 1 and `io_out_valid` = 0 during reset.
REQ-022 SHALL keep data registers free of reset and zero the outputs while `io_out_valid` = 0.
REQ-023 SHALL discard in-flight operands on reset asserted mid-operation; no result emerges afterwards.

Configuration
REQ-024 SHALL use macro RECFN_TO_FN_CANON_NAN_EN to select NaN output:
- Defined: every NaN output = 64'h7FF8_0000_0000_0000 and class bit 9 is still set only for qNaN inputs.
- Undefined: NaN sign and payload pass through per REQ-018.

Structure
REQ-025 SHALL place constants in shared package rec_fn_pkg: EXP_W = 11, SIG_W = 53, MIN_NORM_EXP = 1026, EXP_BIAS_OFF = 1025, MIN_SUB_EXP = 974, CANON_NAN_64, fclass bit indices.
REQ-026 SHALL instantiate one combinational sub-module, rec_fn_classify, in S1: recoded in -> {isZero, isInf, isNaN, isSub, isNormal, sign}.

Verification
REQ-027 SHALL cover:
- Normal: in 65'h0_8000_0000_0000_0000 -> out 64'h3FF0_0000_0000_0000, class bit 6, 2 cycles later.
- Infinity: in 65'h1_C000_0000_0000_0000 -> 64'hFFF0_0000_0000_0000, bit 0.
- Subnormal: in exp 974, fract 0 (65'h0_3CE0_0000_0000_0000) -> 64'h0000_0000_0000_0001, bit 5; exp 1025, fract 0 -> 64'h0008_0000_0000_0000.
- NaN: in 65'h1_E000_0000_0000_0001 -> 64'hFFF0_0000_0000_0001 with bit 8 (macro off); 64'h7FF8_0000_0000_0000 (macro on).
- Back-pressure: 4 back-to-back operands with `io_out_ready` toggling 1,0,0,1,... -> all 4 results in order, each held stable while stalled, and `io_in_ready` = 0 only when both stages are full and stalled.
- Reset mid-flight: 2 operands accepted, then `reset` = 0 for 1 cycle -> `io_out_valid` = 0 and no stale result appears afterwards.
